// File: rtl/placar_pontos_pkg.sv
// Shared types and default constants for the score/lives keeper.
package placar_pontos_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        JOGANDO = 2'd1,
        FIM     = 2'd2
    } estado_t;

    localparam int DEF_MAX_PONTOS   = 99;
    localparam int DEF_VIDAS_INI    = 3;
    localparam int DEF_BLINK_CICLOS = 25_000_000;

    localparam int PONTOS_W = 7;
    localparam int VIDAS_W  = 2;

endpackage

// File: rtl/placar_pontos_if.sv
// Game event inputs and score/lives outputs of the score keeper.
interface placar_pontos_if;
    import placar_pontos_pkg::*;

    logic                start;
    logic                acerto;
    logic                erro;
    logic [PONTOS_W-1:0] pontos;
    logic                enable;
    logic [VIDAS_W-1:0]  vidas;
    logic                jogando;
    logic                fim_jogo;

    // Event source side (buttons / game logic).
    modport master (
        output start, acerto, erro,
        input  pontos, enable, vidas, jogando, fim_jogo
    );

    // Score keeper side.
    modport slave (
        input  start, acerto, erro,
        output pontos, enable, vidas, jogando, fim_jogo
    );
endinterface

// File: rtl/placar_pontos_sinc_borda.sv
// One-bit 2-flop synchronizer plus rising-edge detector. The detector is
// only armed after a valid low level has been observed, so an input that is
// already high when reset is released never produces a pulse.
module sinc_borda (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulso
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;
    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic armado_q, armado_d;

    // Next-state: shift the input through the synchronizer; v1/v2 mark when
    // s2 carries a real sample instead of its reset value.
    always_comb begin
        s1_d     = din;
        s2_d     = s1_q;
        s3_d     = s2_q;
        v1_d     = 1'b1;
        v2_d     = v1_q;
        armado_d = armado_q | (v2_q & ~s2_q);
    end

    // Register stage with asynchronous clear.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            armado_q <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            armado_q <= armado_d;
        end
    end

    assign pulso = s2_q & ~s3_q & armado_q;

endmodule

// File: rtl/placar_pontos.sv
// Game score keeper: counts hits (saturating), lives, and drives the score
// display enable, which blinks while the game is over.
module placar_pontos
    import placar_pontos_pkg::*;
#(
    parameter int MAX_PONTOS   = DEF_MAX_PONTOS,
    parameter int VIDAS_INI    = DEF_VIDAS_INI,
    parameter int BLINK_CICLOS = DEF_BLINK_CICLOS
) (
    input logic            clk,
    input logic            rst_n,
    placar_pontos_if.slave bus
);

    localparam int CNT_W = (BLINK_CICLOS > 1) ? $clog2(BLINK_CICLOS) : 1;
    localparam logic [CNT_W-1:0]    CNT_ULT  = CNT_W'(BLINK_CICLOS - 1);
    localparam logic [PONTOS_W-1:0] PTS_MAX  = PONTOS_W'(MAX_PONTOS);
    localparam logic [VIDAS_W-1:0]  VIDAS_LD = VIDAS_W'(VIDAS_INI);

    logic p_start, p_acerto, p_erro;

    sinc_borda u_sinc_start  (.clk(clk), .rst_n(rst_n), .din(bus.start),  .pulso(p_start));
    sinc_borda u_sinc_acerto (.clk(clk), .rst_n(rst_n), .din(bus.acerto), .pulso(p_acerto));
    sinc_borda u_sinc_erro   (.clk(clk), .rst_n(rst_n), .din(bus.erro),   .pulso(p_erro));

    estado_t             estado_q, estado_d;
    logic [PONTOS_W-1:0] pontos_q, pontos_d;
    logic [VIDAS_W-1:0]  vidas_q, vidas_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                enable_q, enable_d;
    logic                jogando_q, jogando_d;
    logic                fim_q, fim_d;

    // Next-state and next-output logic for the game FSM and blink counter.
    // NOTE: every variable gets a default at the top so no path through the
    // case statements leaves one unassigned (which would infer a latch).
    always_comb begin
        estado_d = estado_q;
        pontos_d = pontos_q;
        vidas_d  = vidas_q;
        cnt_d    = '0;
        enable_d = 1'b0;

        unique case (estado_q)
            OCIOSO: begin
                if (p_start) begin
                    estado_d = JOGANDO;
                    pontos_d = '0;
                    vidas_d  = VIDAS_LD;
                end
            end
            JOGANDO: begin
                if (p_acerto && (pontos_q < PTS_MAX)) begin
                    pontos_d = pontos_q + 1'b1;
                end
                if (p_erro) begin
                    vidas_d = vidas_q - 1'b1;
                    if (vidas_q == 2'd1) begin
                        estado_d = FIM;
                    end
                end
            end
            FIM: begin
                if (p_start) begin
                    estado_d = JOGANDO;
                    pontos_d = '0;
                    vidas_d  = VIDAS_LD;
                end
            end
            default: estado_d = OCIOSO;
        endcase

        // Display enable follows the state being entered, so it is registered
        // together with it; the blink starts high on the edge entering FIM.
        if (estado_d == JOGANDO) begin
            enable_d = 1'b1;
        end else if (estado_d == FIM) begin
            if (estado_q != FIM) begin
                enable_d = 1'b1;
            end else if (cnt_q == CNT_ULT) begin
                enable_d = ~enable_q;
            end else begin
                cnt_d    = cnt_q + 1'b1;
                enable_d = enable_q;
            end
        end

        jogando_d = (estado_d == JOGANDO);
        fim_d     = (estado_d == FIM);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= OCIOSO;
            pontos_q  <= '0;
            vidas_q   <= '0;
            cnt_q     <= '0;
            enable_q  <= 1'b0;
            jogando_q <= 1'b0;
            fim_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            pontos_q  <= pontos_d;
            vidas_q   <= vidas_d;
            cnt_q     <= cnt_d;
            enable_q  <= enable_d;
            jogando_q <= jogando_d;
            fim_q     <= fim_d;
        end
    end

    assign bus.pontos   = pontos_q;
    assign bus.vidas    = vidas_q;
    assign bus.enable   = enable_q;
    assign bus.jogando  = jogando_q;
    assign bus.fim_jogo = fim_q;

endmodule

// File: tb/tb_placar_pontos.sv
// Directed bench for placar_pontos with a short blink period.
module tb_placar_pontos;
    import placar_pontos_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    placar_pontos_if bus ();

    placar_pontos #(
        .MAX_PONTOS  (99),
        .VIDAS_INI   (3),
        .BLINK_CICLOS(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       acerto;
        logic       erro;
        int         reps;
        logic [6:0] pontos;
        logic [1:0] vidas;
        logic       jogando;
        logic       fim;
        logic       en;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Raise the selected inputs for 'hi' cycles, then hold them low for 'lo'.
    task automatic evento(input logic s, input logic a, input logic e, input int hi, input int lo);
        bus.start  = s;
        bus.acerto = a;
        bus.erro   = e;
        repeat (hi) @(negedge clk);
        bus.start  = 1'b0;
        bus.acerto = 1'b0;
        bus.erro   = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic check_all(input string tag, input logic [6:0] p, input logic [1:0] v,
                             input logic j, input logic f, input logic en);
        check({tag, ".pontos"},   32'(bus.pontos),   32'(p));
        check({tag, ".vidas"},    32'(bus.vidas),    32'(v));
        check({tag, ".jogando"},  32'(bus.jogando),  32'(j));
        check({tag, ".fim_jogo"}, 32'(bus.fim_jogo), 32'(f));
        check({tag, ".enable"},   32'(bus.enable),   32'(en));
    endtask

    initial begin
        logic [6:0] base;
        int         exp_p;
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b1;
        bus.start  = 1'b0;
        bus.acerto = 1'b0;
        bus.erro   = 1'b0;

        //                 st   ac   er  reps pts  vid  jog  fim  en
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1, 7'd0, 2'd0, 1'b0, 1'b0, 1'b0}; // hit ignored idle
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1, 7'd0, 2'd0, 1'b0, 1'b0, 1'b0}; // miss ignored idle
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1, 7'd0, 2'd3, 1'b1, 1'b0, 1'b1}; // start
        vecs[3] = '{1'b0, 1'b1, 1'b0, 5, 7'd5, 2'd3, 1'b1, 1'b0, 1'b1}; // 5 hits
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1, 7'd5, 2'd3, 1'b1, 1'b0, 1'b1}; // start ignored
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1, 7'd5, 2'd2, 1'b1, 1'b0, 1'b1}; // miss
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1, 7'd6, 2'd1, 1'b1, 1'b0, 1'b1}; // hit+miss
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1, 7'd7, 2'd0, 1'b0, 1'b1, 1'b1}; // hit+miss last life

        // Reset state
        #2 rst_n = 1'b0;
        #1 check_all("reset", 7'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Table-driven sequence
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                evento(vecs[i].start, vecs[i].acerto, vecs[i].erro, 2, 3);
            end
            check_all($sformatf("vec%0d", i), vecs[i].pontos, vecs[i].vidas,
                      vecs[i].jogando, vecs[i].fim, vecs[i].en);
        end

        // Game over: score and lives frozen
        evento(1'b0, 1'b1, 1'b0, 2, 3);
        check("fim_acerto_ignored", 32'(bus.pontos), 32'd7);
        evento(1'b0, 1'b0, 1'b1, 2, 3);
        check("fim_erro_ignored", 32'(bus.vidas), 32'd0);
        check("fim_state_held", 32'(bus.fim_jogo), 32'd1);

        // Restart from game over reloads score and lives
        evento(1'b1, 1'b0, 1'b0, 2, 3);
        check_all("restart", 7'd0, 2'd3, 1'b1, 1'b0, 1'b1);

        // Three misses, then watch the blink from the edge entering FIM
        evento(1'b0, 1'b0, 1'b1, 2, 3);
        evento(1'b0, 1'b0, 1'b1, 2, 3);
        evento(1'b0, 1'b0, 1'b1, 2, 1);
        check("blink_entry_fim", 32'(bus.fim_jogo), 32'd1);
        check("blink_entry_jog", 32'(bus.jogando), 32'd0);
        check("blink_entry_vidas", 32'(bus.vidas), 32'd0);
        for (int j = 0; j < 20; j++) begin
            check($sformatf("blink_j%0d", j), 32'(bus.enable), (((j / 4) % 2) == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        evento(1'b0, 1'b1, 1'b0, 2, 3);
        check("blink_acerto_ignored", 32'(bus.pontos), 32'd0);

        // Saturation at 99 over 120 hits
        evento(1'b1, 1'b0, 1'b0, 2, 3);
        for (int i = 0; i < 120; i++) begin
            evento(1'b0, 1'b1, 1'b0, 2, 2);
            exp_p = (i + 1 > 99) ? 99 : i + 1;
            check($sformatf("sat_%0d", i), 32'(bus.pontos), 32'(exp_p));
        end

        // Held level gives exactly one increment, two edges after sampling
        evento(1'b1, 1'b0, 1'b0, 2, 3); // start ignored while playing
        check("held_pre", 32'(bus.pontos), 32'd99);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        evento(1'b1, 1'b0, 1'b0, 2, 3);
        base = bus.pontos;
        check("held_base", 32'(base), 32'd0);
        bus.acerto = 1'b1;
        @(negedge clk);
        check("held_k", 32'(bus.pontos), 32'd0);
        @(negedge clk);
        check("held_k1", 32'(bus.pontos), 32'd0);
        @(negedge clk);
        check("held_k2", 32'(bus.pontos), 32'd1);
        repeat (47) @(negedge clk);
        check("held_50", 32'(bus.pontos), 32'd1);
        bus.acerto = 1'b0;
        repeat (3) @(negedge clk);
        check("held_after", 32'(bus.pontos), 32'd1);

        // Reach 7 points, then reset mid-game with acerto held through release
        for (int i = 0; i < 6; i++) evento(1'b0, 1'b1, 1'b0, 2, 2);
        check("rst_pre_pontos", 32'(bus.pontos), 32'd7);
        bus.acerto = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_all("rst_mid", 7'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_rel_pontos", 32'(bus.pontos), 32'd0);
        check("rst_rel_jog", 32'(bus.jogando), 32'd0);
        bus.start = 1'b1;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_held_jog", 32'(bus.jogando), 32'd1);
        check("rst_held_pontos", 32'(bus.pontos), 32'd0);
        bus.acerto = 1'b0;
        repeat (2) @(negedge clk);
        evento(1'b0, 1'b1, 1'b0, 2, 3);
        check("rst_rearm_pontos", 32'(bus.pontos), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/placar_pontos.md
PLACAR_PONTOS -- requirements
Module: placar_pontos

Interface
REQ-001 Parameter MAX_PONTOS, default 99: saturation value of the score, legal range 1..127.
REQ-002 Parameter VIDAS_INI, default 3: lives loaded at game start, legal range 1..3.
REQ-003 Parameter BLINK_CICLOS, default 25_000_000: clk cycles per half-period of the game-over blink.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-006 start  in  1  game start request, asynchronous to clk, level.
REQ-007 acerto  in  1  hit event, asynchronous to clk, level.
REQ-008 erro  in  1  miss event, asynchronous to clk, level.
REQ-009 pontos  out  7  current score, unsigned binary, drives the score display input.
REQ-010 enable  out  1  score display enable, high shows digits, low blanks.
REQ-011 vidas  out  2  remaining lives, unsigned.
REQ-012 jogando  out  1  high while state is JOGANDO.
REQ-013 fim_jogo  out  1  high while state is FIM.

Function
REQ-014 start, acerto and erro shall each pass a 2-flop synchronizer followed by a rising-edge detector, giving a one-cycle internal pulse.
REQ-015 An input rising edge first sampled at clk edge k shall take effect on state and outputs at clk edge k+2; a held level shall produce exactly one pulse.
REQ-016 FSM states: OCIOSO, JOGANDO, FIM; encoding is free.
REQ-017 OCIOSO: start pulse -> JOGANDO, pontos <= 0, vidas <= VIDAS_INI; acerto/erro pulses ignored.
REQ-018 JOGANDO: acerto pulse -> pontos <= pontos+1, saturating at MAX_PONTOS (no wrap).
REQ-019 JOGANDO: erro pulse -> vidas <= vidas-1; when vidas is 1 the decrement yields 0 and state -> FIM on the same edge.
REQ-020 JOGANDO: acerto and erro pulses on the same cycle shall both apply (score incremented, life decremented), including the final-life case.
REQ-021 JOGANDO: start pulses ignored.
REQ-022 FIM: pontos and vidas frozen; acerto/erro ignored; start pulse -> JOGANDO with the REQ-017 reloads.
REQ-023 enable: low in OCIOSO, high in JOGANDO, toggling in FIM.
REQ-024 FIM blink: high for BLINK_CICLOS cycles, then low for BLINK_CICLOS cycles, repeating.
REQ-025 The first high phase of the blink shall begin on the edge that enters FIM.
REQ-026 The blink counter shall be held at zero outside FIM.
REQ-027 All outputs shall be registered; no combinational path from any input to any output.

Reset
REQ-028 rst_n low shall immediately force state OCIOSO, pontos=0, vidas=0, enable=0, jogando=0, fim_jogo=0, blink counter 0 and all synchronizer/edge flops 0.
REQ-029 Reset asserted mid-game shall discard score and lives; no event pulse shall be generated from levels already high at reset release until they go low and high again.

Structure
REQ-030 A shared package shall hold the FSM state typedef and the default constants MAX_PONTOS, VIDAS_INI and BLINK_CICLOS.
REQ-031 One sub-module sinc_borda (2-flop synchronizer plus rising-edge detector, one bit) shall be instantiated three times.
REQ-032 pontos shall connect directly to the existing score display block's 7-bit score input, and enable to its enable input.

Verification (BLINK_CICLOS=4 in bench)
REQ-033 Reset, start pulse, 5 acerto pulses -> jogando=1, pontos=5, vidas=3, enable=1.
REQ-034 Start, 120 acerto pulses -> pontos saturates at 99 and never wraps.
REQ-035 Start, 3 erro pulses -> after the third: vidas=0, fim_jogo=1, jogando=0, enable toggles 4 high / 4 low; further acerto pulses leave pontos unchanged.
REQ-036 vidas=1, acerto and erro rising on the same edge -> pontos+1, vidas=0, state FIM.
REQ-037 acerto held high for 50 cycles -> pontos rises by exactly 1, at the second edge after first sampling.
REQ-038 rst_n low mid-game with pontos=7 -> all outputs 0 immediately; acerto held high through reset release -> no increment.
